// File: rtl/flag_debounce.sv
// flag_debounce
// Synchronizes an asynchronous, idle-high, possibly bouncing flag into clk and
// debounces it with a consecutive-cycle stability counter.
// A level change is accepted only after it has been seen for DEBOUNCE_CYCLES
// consecutive enabled cycles. A mismatch that ends early is counted as a
// rejected glitch in a saturating 8-bit counter.
module flag_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_flag,
   input  logic       en,
   input  logic       glitch_clr,
   output logic       clean_flag,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   // Counter value on which a persisting mismatch is accepted.
   localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_QUAL = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q_s;
   logic                   mismatch_s;
   logic                   reject_s;
   state_t                 state_r;
   logic [15:0]            cnt_r;
   logic                   clean_r;
   logic                   busy_r;
   logic [7:0]             glitch_r;

   assign sync_q_s   = sync_r[SYNC_STAGES-1];
   assign mismatch_s = sync_q_s ^ clean_r;

   assign clean_flag = clean_r;
   assign busy       = busy_r;
   assign glitch_cnt = glitch_r;

   // Synchronizer shift register; resets to the idle-high level and keeps running regardless of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw_flag};
      end
   end

   // Qualification FSM: times a mismatch, accepts it after the full window, drops it when it ends early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         clean_r <= 1'b1;
         busy_r  <= 1'b0;
      end else if (!en) begin
         // Disabled: abandon any pending change without counting it as a glitch.
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (mismatch_s) begin
                  state_r <= ST_QUAL;
                  cnt_r   <= 16'd1;
                  busy_r  <= 1'b1;
               end else begin
                  cnt_r   <= 16'd0;
                  busy_r  <= 1'b0;
               end
            end
            ST_QUAL: begin
               if (mismatch_s && (cnt_r == LAST_CNT)) begin
                  // ACCEPT: the new level persisted for the whole window.
                  clean_r <= sync_q_s;
                  state_r <= ST_IDLE;
                  cnt_r   <= 16'd0;
                  busy_r  <= 1'b0;
               end else if (mismatch_s) begin
                  cnt_r   <= cnt_r + 16'd1;
                  busy_r  <= 1'b1;
               end else begin
                  // REJECT: the level fell back before the window completed.
                  state_r <= ST_IDLE;
                  cnt_r   <= 16'd0;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 16'd0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // A REJECT is a match observed while a mismatch is being timed with en high.
   always_comb begin
      reject_s = 1'b0;
      if (en && (state_r == ST_QUAL) && !mismatch_s) begin
         reject_s = 1'b1;
      end else begin
         reject_s = 1'b0;
      end
   end

   // Saturating glitch counter; a clear wins over a simultaneous REJECT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_r <= 8'd0;
      end else if (glitch_clr) begin
         glitch_r <= 8'd0;
      end else if (reject_s && (glitch_r != 8'd255)) begin
         glitch_r <= glitch_r + 8'd1;
      end else begin
         glitch_r <= glitch_r;
      end
   end

endmodule

// File: tb/tb_flag_debounce.sv
// tb_flag_debounce
// Directed scenarios plus randomized stimulus, every cycle compared against a
// behavioural model of the debouncer built from the level-acceptance rules.
module tb_flag_debounce;

   localparam int SYNC = 2;
   localparam int DEB  = 16;

   logic       clk;
   logic       rst;
   logic       raw_flag;
   logic       en;
   logic       glitch_clr;
   logic       clean_flag;
   logic       busy;
   logic [7:0] glitch_cnt;

   int n_vec;
   int n_err;

   // Model state.
   bit m_pipe[$];   // raw samples still travelling through the synchronizer
   bit m_clean;     // accepted level
   int m_run;       // consecutive enabled cycles the synchronized level has differed
   int m_glitch;    // rejected transitions, saturating

   flag_debounce #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .raw_flag  (raw_flag),
      .en        (en),
      .glitch_clr(glitch_clr),
      .clean_flag(clean_flag),
      .busy      (busy),
      .glitch_cnt(glitch_cnt)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b1);
      m_clean  = 1'b1;
      m_run    = 0;
      m_glitch = 0;
   endtask

   // One rising edge of the model: the synchronized value is the raw sample from SYNC edges ago.
   task automatic model_step();
      bit seen;
      bit rej;
      seen = m_pipe.pop_front();
      m_pipe.push_back(raw_flag);
      rej = 1'b0;
      if (!en) begin
         m_run = 0;
      end else if (seen != m_clean) begin
         m_run = m_run + 1;
         if (m_run == DEB) begin
            m_clean = seen;
            m_run   = 0;
         end
      end else begin
         rej   = (m_run > 0);
         m_run = 0;
      end
      if (glitch_clr) m_glitch = 0;
      else if (rej && m_glitch < 255) m_glitch = m_glitch + 1;
   endtask

   task automatic check_all(input string where);
      chk({where, ".clean"}, {15'd0, clean_flag}, {15'd0, m_clean});
      chk({where, ".busy"}, {15'd0, busy}, (m_run != 0) ? 16'd1 : 16'd0);
      chk({where, ".gcnt"}, {8'd0, glitch_cnt}, 16'(m_glitch));
   endtask

   // Advance one clock, step the model, then compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check_all("cyc");
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Count edges until clean_flag reaches v; returns limit+1 if it never does.
   task automatic wait_clean(input logic v, input int limit, output int n);
      n = limit + 1;
      for (int k = 1; k <= limit; k++) begin
         cycle();
         if (clean_flag === v) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst");
   endtask

   initial begin
      int n;
      int nb;
      int rem;
      n_vec      = 0;
      n_err      = 0;
      raw_flag   = 1'b0;
      en         = 1'b1;
      glitch_clr = 1'b0;
      rst        = 1'b0;

      // Reset values with raw_flag low, then release and time the fall.
      @(negedge clk);
      do_reset();
      chk("rst_clean", {15'd0, clean_flag}, 16'd1);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_gcnt", {8'd0, glitch_cnt}, 16'd0);
      run(2);
      rst = 1'b0;
      wait_clean(1'b0, 40, n);
      chk("rel_latency", 16'(n), 16'd18);

      // Back to high, then a clean fall with busy measured.
      raw_flag = 1'b1;
      run(30);
      chk("rise_clean", {15'd0, clean_flag}, 16'd1);
      raw_flag = 1'b0;
      nb = 0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         if (busy) nb++;
      end
      chk("fall_busy", 16'(nb), 16'd15);
      chk("fall_clean", {15'd0, clean_flag}, 16'd0);
      chk("fall_gcnt", {8'd0, glitch_cnt}, 16'd0);
      raw_flag = 1'b1;
      run(30);

      // Glitch rejection: 5-cycle and 15-cycle low pulses.
      raw_flag = 1'b0; run(5);
      raw_flag = 1'b1; run(20);
      chk("glitch5_clean", {15'd0, clean_flag}, 16'd1);
      chk("glitch5_gcnt", {8'd0, glitch_cnt}, 16'd1);
      raw_flag = 1'b0; run(15);
      raw_flag = 1'b1; run(20);
      chk("glitch15_clean", {15'd0, clean_flag}, 16'd1);
      chk("glitch15_gcnt", {8'd0, glitch_cnt}, 16'd2);

      // Saturation after 260 glitches.
      for (int g = 0; g < 260; g++) begin
         raw_flag = 1'b0; run(5);
         raw_flag = 1'b1; run(5);
      end
      chk("sat_gcnt", {8'd0, glitch_cnt}, 16'd255);

      // Clear on the very edge of a REJECT: raw low 5, high; REJECT lands on the third edge after.
      raw_flag = 1'b0; run(5);
      raw_flag = 1'b1; run(2);
      chk("pre_clr_busy", {15'd0, busy}, 16'd1);
      glitch_clr = 1'b1; cycle();
      glitch_clr = 1'b0;
      chk("clr_prio", {8'd0, glitch_cnt}, 16'd0);
      run(5);

      // Enable gating: 10 mismatch cycles, drop en, then restore.
      raw_flag = 1'b0; run(12);
      chk("en_busy_before", {15'd0, busy}, 16'd1);
      en = 1'b0; run(6);
      chk("en_off_busy", {15'd0, busy}, 16'd0);
      chk("en_off_gcnt", {8'd0, glitch_cnt}, 16'd0);
      chk("en_off_clean", {15'd0, clean_flag}, 16'd1);
      en = 1'b1;
      wait_clean(1'b0, 40, n);
      chk("en_latency", 16'(n), 16'd16);
      raw_flag = 1'b1; run(30);

      // Reset in the middle of a qualification.
      raw_flag = 1'b0; run(14);
      chk("mid_busy", {15'd0, busy}, 16'd1);
      do_reset();
      chk("mid_rst_clean", {15'd0, clean_flag}, 16'd1);
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      run(2);
      rst = 1'b0;
      wait_clean(1'b0, 40, n);
      chk("mid_rel_latency", 16'(n), 16'd18);

      // Randomized traffic against the model.
      rem = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rem == 0) begin
            raw_flag = ~raw_flag;
            rem = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 24) : $urandom_range(1, 20);
         end
         rem--;
         en         = ($urandom_range(0, 24) != 0);
         glitch_clr = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            cycle();
            rst = 1'b0;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
